// File: rtl/pipeline_ctrl.sv
// Hazard and latch-sequencing controller for the 5-stage pipeline.
// Optional perf counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int unsigned REGW  = 5,
    parameter int unsigned PERFW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dREN,
    input  logic            mem_dWEN,
    input  logic            mem_halt,
    input  logic            ex_dREN,
    input  logic [REGW-1:0] ex_regDst,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_usesRt,
    input  logic            ex_brtaken,
    input  logic            ex_jump,
    output logic            pcen,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic            memwb_flush,
    output logic            halted,
    output logic            imemREN
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [PERFW-1:0] stall_cnt,
    output logic [PERFW-1:0] flush_cnt,
    output logic [PERFW-1:0] dwait_cnt
`endif
);

    typedef enum logic [1:0] {StRun, StDmemWait, StDrain, StHalted} state_e;

    state_e state_q, state_d;
    logic   memreq, redirect, load_use;
    logic   ev_stall, ev_flush, ev_dwait;

    always_comb begin
        memreq   = mem_dREN | mem_dWEN;
        redirect = ex_brtaken | ex_jump;
        // Register 0 is hardwired, so a load targeting it never creates a hazard.
        load_use = ex_dREN && (ex_regDst != '0) &&
                   ((ex_regDst == id_rs) || (id_usesRt && (ex_regDst == id_rt)));
    end

    always_comb begin
        state_d     = state_q;
        pcen        = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        imemREN     = 1'b0;
        ev_stall    = 1'b0;
        ev_flush    = 1'b0;
        ev_dwait    = 1'b0;

        if (RST) begin
            state_d     = StRun;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun, StDmemWait: begin
                    imemREN = 1'b1;
                    if (mem_halt) begin
                        state_d     = StDrain;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (memreq && !dhit) begin
                        // Freeze everything upstream of MEM; bubble into WB.
                        state_d     = StDmemWait;
                        memwb_flush = 1'b1;
                        ev_dwait    = 1'b1;
                    end else begin
                        state_d  = StRun;
                        pcen     = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (redirect) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                            ev_flush   = 1'b1;
                        end else begin
                            if (load_use) begin
                                pcen       = 1'b0;
                                ifid_en    = 1'b0;
                                idex_flush = 1'b1;
                                ev_stall   = 1'b1;
                            end
                            if (!ihit) begin
                                pcen       = 1'b0;
                                ifid_flush = 1'b1;
                            end
                        end
                    end
                end
                StDrain: begin
                    state_d     = StHalted;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                end
                StHalted: begin
                    halted = 1'b1;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    // Event flags are only raised in RUN/DMEM_WAIT, so counters freeze once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            dwait_cnt <= '0;
        end else begin
            if (ev_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (ev_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            if (ev_dwait && (dwait_cnt != '1)) dwait_cnt <= dwait_cnt + 1'b1;
        end
    end
`else
    logic unused_ev;
    assign unused_ev = ev_stall ^ ev_flush ^ ev_dwait;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes hand-computed output vectors,
// a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

    localparam int unsigned REGW  = 5;
    localparam int unsigned PERFW = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic            ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN;
    logic [REGW-1:0] ex_regDst, id_rs, id_rt;
    logic            id_usesRt, ex_brtaken, ex_jump;
    logic            pcen, ifid_en, ifid_flush, idex_en, idex_flush;
    logic            exmem_en, exmem_flush, memwb_en, memwb_flush, halted, imemREN;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [PERFW-1:0] stall_cnt, flush_cnt, dwait_cnt;
`endif

    pipeline_ctrl #(.REGW(REGW), .PERFW(PERFW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_regDst(ex_regDst), .id_rs(id_rs), .id_rt(id_rt),
        .id_usesRt(id_usesRt), .ex_brtaken(ex_brtaken), .ex_jump(ex_jump),
        .pcen(pcen), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .imemREN(imemREN)
`ifdef PIPELINE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // {pcen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
    //  memwb_en, memwb_flush, halted, imemREN}
    localparam logic [10:0] E_RST   = 11'b0_01_01_01_01_0_0;
    localparam logic [10:0] E_RUN   = 11'b1_10_10_10_10_0_1;
    localparam logic [10:0] E_LU    = 11'b0_00_11_10_10_0_1;
    localparam logic [10:0] E_LUMIS = 11'b0_01_11_10_10_0_1;
    localparam logic [10:0] E_MISS  = 11'b0_11_10_10_10_0_1;
    localparam logic [10:0] E_BR    = 11'b1_11_11_10_10_0_1;
    localparam logic [10:0] E_DWAIT = 11'b0_00_00_00_01_0_1;
    localparam logic [10:0] E_HALT  = 11'b0_01_01_01_10_0_1;
    localparam logic [10:0] E_DRAIN = 11'b0_01_01_01_10_0_0;
    localparam logic [10:0] E_HALTD = 11'b0_00_00_00_00_1_0;

    logic [10:0] exp_q[$];
    string       nm_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e, got;
            string       nm;
            e   = exp_q.pop_front();
            nm  = nm_q.pop_front();
            got = {pcen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
                   memwb_en, memwb_flush, halted, imemREN};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", nm, got, e);
            end
        end
    end

    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_halt = 1'b0; ex_dREN = 1'b0; ex_regDst = '0; id_rs = '0; id_rt = '0;
        id_usesRt = 1'b0; ex_brtaken = 1'b0; ex_jump = 1'b0;
    endtask

    task automatic cyc(input logic [10:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lu(input logic [REGW-1:0] dst, input logic [REGW-1:0] rs,
                          input logic [REGW-1:0] rt, input logic uses_rt);
        ex_dREN = 1'b1; ex_regDst = dst; id_rs = rs; id_rt = rt; id_usesRt = uses_rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        cyc(E_RST, "reset0");
        cyc(E_RST, "reset1");
        RST = 1'b0;
        cyc(E_RUN, "run_idle");

        set_lu(5'd5, 5'd5, 5'd0, 1'b0); cyc(E_LU, "lu_rs");
        set_lu(5'd0, 5'd0, 5'd0, 1'b1); cyc(E_RUN, "lu_r0");
        set_lu(5'd7, 5'd3, 5'd7, 1'b1); cyc(E_LU, "lu_rt");
        set_lu(5'd7, 5'd3, 5'd7, 1'b0); cyc(E_RUN, "lu_rt_unused");
        set_lu(5'd9, 5'd9, 5'd0, 1'b0); ihit = 1'b0; cyc(E_LUMIS, "lu_and_miss");
        idle();

        mem_dREN = 1'b1; dhit = 1'b0;
        cyc(E_DWAIT, "dwait0");
        cyc(E_DWAIT, "dwait1");
        cyc(E_DWAIT, "dwait2");
        dhit = 1'b1; cyc(E_RUN, "dwait_hit");
        idle(); cyc(E_RUN, "dwait_back_run");

        ex_brtaken = 1'b1; ihit = 1'b0; set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        cyc(E_BR, "br_miss_lu");
        idle(); ihit = 1'b0; cyc(E_MISS, "fetch_miss");
        idle();

        ex_jump = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
        cyc(E_DWAIT, "jmp_stall0");
        cyc(E_DWAIT, "jmp_stall1");
        dhit = 1'b1; cyc(E_BR, "jmp_on_dhit");
        idle();

        mem_dREN = 1'b1; dhit = 1'b0; cyc(E_DWAIT, "abandon_wait");
        RST = 1'b1; cyc(E_RST, "abandon_rst");
        idle(); cyc(E_RUN, "abandon_run");

        mem_halt = 1'b1; cyc(E_HALT, "halt");
        idle(); cyc(E_DRAIN, "drain");
        cyc(E_HALTD, "halted0");
        ex_jump = 1'b1; mem_halt = 1'b1; set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        cyc(E_HALTD, "halted1");
        idle(); cyc(E_HALTD, "halted2");
        RST = 1'b1; cyc(E_RST, "halt_rst");
        idle(); cyc(E_RUN, "post_rst_run");

        set_lu(5'd4, 5'd4, 5'd0, 1'b0); cyc(E_LU, "perf_lu0");
        set_lu(5'd6, 5'd1, 5'd6, 1'b1); cyc(E_LU, "perf_lu1");
        idle(); ex_brtaken = 1'b1; cyc(E_BR, "perf_br");
        idle(); mem_dWEN = 1'b1; dhit = 1'b0;
        cyc(E_DWAIT, "perf_dw0");
        cyc(E_DWAIT, "perf_dw1");
        cyc(E_DWAIT, "perf_dw2");
        idle(); cyc(E_RUN, "perf_end");

`ifdef PIPELINE_CTRL_PERF_EN
        n_cmp++;
        if (stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stall_cnt: got %0d required 2", stall_cnt);
        end
        n_cmp++;
        if (flush_cnt !== 16'd1) begin
            n_fail++; $display("FAIL flush_cnt: got %0d required 1", flush_cnt);
        end
        n_cmp++;
        if (dwait_cnt !== 16'd3) begin
            n_fail++; $display("FAIL dwait_cnt: got %0d required 3", dwait_cnt);
        end
`endif

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and latch-sequencing controller for the 5-stage pipeline. It drives the enable/flush pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves four hazard classes: data-memory wait, instruction-fetch miss, taken branch/jump in EX, and load-use.
- Sequences halt drain into a sticky halted state.
- Sits beside the datapath; its idex/exmem outputs feed the flush/exen controls of the execute latch.

Parameters:
- REGW, 5, register-index width (regbits_t).
- PERFW, 16, perf-counter width (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  instruction memory returned the fetch this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- mem_dREN  in  1  EX/MEM latch holds a load.
- mem_dWEN  in  1  EX/MEM latch holds a store.
- mem_halt  in  1  EX/MEM latch holds a halt.
- ex_dREN  in  1  ID/EX latch holds a load.
- ex_regDst  in  REGW  destination register of the ID/EX instruction.
- id_rs  in  REGW  rs of the IF/ID instruction.
- id_rt  in  REGW  rt of the IF/ID instruction.
- id_usesRt  in  1  IF/ID instruction reads rt as a source.
- ex_brtaken  in  1  branch resolved taken in EX.
- ex_jump  in  1  jump/jr in EX.
- pcen  out  1  PC register load enable.
- ifid_en, ifid_flush  out  1 each  IF/ID latch control.
- idex_en, idex_flush  out  1 each  ID/EX latch control.
- exmem_en, exmem_flush  out  1 each  EX/MEM latch control.
- memwb_en, memwb_flush  out  1 each  MEM/WB latch control.
- halted  out  1  processor halted (sticky).
- imemREN  out  1  instruction fetch request.

Behaviour:
- Latch semantics: flush=1 forces the latch to a bubble on the clock edge and overrides en. en=0 with flush=0 holds the latch.
- State register: RUN, DMEM_WAIT, DRAIN, HALTED. On RST the state becomes RUN.
- Outputs are combinational from state and inputs, with zero latency.
- Reset-cycle outputs (RST high): all en=0, all flush=1, pcen=0, halted=0, imemREN=0.
- memreq = mem_dREN | mem_dWEN.
- Output priority in RUN and DMEM_WAIT, highest first:
  1. mem_halt=1: go to DRAIN. This cycle: pcen=0, ifid_flush=idex_flush=exmem_flush=1, memwb_en=1. The halt enters MEM/WB.
  2. memreq & !dhit: pcen=0; ifid_en=idex_en=exmem_en=0; memwb_flush=1. Next state DMEM_WAIT.
  3. Otherwise all en=1. If coming from DMEM_WAIT with dhit=1, the next state is RUN. Hazards below are ANDed on top, in order:
     - a. ex_brtaken|ex_jump: ifid_flush=1, idex_flush=1, pcen=1 (PC loads target). Load-use detection is suppressed.
     - b. load-use, defined as ex_dREN & ex_regDst!=0 & (ex_regDst==id_rs | (id_usesRt & ex_regDst==id_rt)): pcen=0, ifid_en=0, idex_flush=1.
     - c. !ihit (and not rule a): pcen=0, ifid_flush=1.
- Simultaneous !ihit and branch taken: rule a wins. The PC loads the target and the fetched slot is flushed.
- Simultaneous memory stall and branch: rule 2 wins. The branch is held in EX/ID and re-evaluated once dhit arrives.
- DRAIN state (exactly 1 cycle): pcen=0; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1 so the halt retires to WB. Next state HALTED.
- HALTED state: all en=0, all flush=0, pcen=0, imemREN=0, halted=1. Only RST leaves HALTED.
- imemREN=1 in RUN and DMEM_WAIT whenever not in reset.
- RST asserted in any state takes priority over everything: next state RUN, and any pending wait is abandoned.
- Register 0 is never a hazard source.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- When defined, adds three outputs: stall_cnt, flush_cnt, dwait_cnt, each PERFW bits, saturating, cleared by RST, frozen in HALTED.
  - stall_cnt increments on each load-use cycle.
  - flush_cnt increments on each branch/jump flush cycle.
  - dwait_cnt increments on each rule-2 cycle.
- When undefined, the ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Load-use: ex_dREN=1, ex_regDst=5, id_rs=5, ihit=dhit=1. Required: pcen=0, ifid_en=0, idex_flush=1 for one cycle. Repeat with ex_regDst=0: no stall.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1. Required: 3 cycles of frozen PC/IF/ID/EX with memwb_flush=1, state DMEM_WAIT; on the dhit cycle all en=1 and state returns to RUN.
- Branch vs fetch miss: ex_brtaken=1, ihit=0, and a load-use condition also present. Required: pcen=1, ifid_flush=1, idex_flush=1, no ifid_en hold.
- Stall priority: ex_jump=1 with mem_dWEN=1, dhit=0. Required: rule 2 outputs only. The jump flush occurs in the cycle dhit=1.
- Halt: mem_halt=1 for one cycle. Required: DRAIN for 1 cycle with memwb_en=1, then halted=1 and all en=0 indefinitely. Assert RST: halted=0, state RUN, reset outputs as specified.
- With PIPELINE_CTRL_PERF_EN: 2 load-use, 1 branch, 3 dwait cycles. Required: stall_cnt=2, flush_cnt=1, dwait_cnt=3.
